// File: rtl/pmos_bulk_seq_pkg.sv
// rtl/pmos_bulk_seq_pkg.sv - shared types and helpers for the PMOS bulk sequencer
package pmos_bulk_seq_pkg;

   localparam int NBIT_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BREAK = 2'd1,
      MAKE  = 2'd2
   } state_t;

   // Counter must hold max(dead,settle)-1; never narrower than one bit.
   function automatic int timer_w(input int dead, input int settle);
      int m;
      m = (dead > settle) ? dead : settle;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pmos_bulk_seq_timer.sv
// rtl/pmos_bulk_seq_timer.sv - loadable down-counter shared by the dead and settle phases
module cyc_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;

   // Parks at zero; the sequencer always reloads before it would need to wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= value_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pmos_bulk_seq.sv
// rtl/pmos_bulk_seq.sv - break-before-make sequencer for the PMOS finger bulk select bus
module pmos_bulk_seq
   import pmos_bulk_seq_pkg::*;
#(
   parameter int              NBIT       = NBIT_DEF,
   parameter int              DEAD_CYC   = 4,
   parameter int              SETTLE_CYC = 8,
   parameter logic [NBIT-1:0] PARK_CODE  = '1,
   parameter logic [NBIT-1:0] RST_CODE   = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic [NBIT-1:0] req_code,
   output logic            req_ready,
   input  logic            abort,
   output logic [NBIT-1:0] mid,
   output logic            busy,
   output logic            done,
   output logic            aborted
);

   localparam int            TW        = timer_w(DEAD_CYC, SETTLE_CYC);
   localparam logic [TW-1:0] DEAD_LD   = TW'(DEAD_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

   if (DEAD_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_param
      $error("pmos_bulk_seq: DEAD_CYC and SETTLE_CYC must both be >= 1");
   end

   state_t            state_q;
   logic [NBIT-1:0]   mid_q;
   logic [NBIT-1:0]   cur_code_q;
   logic [NBIT-1:0]   nxt_code_q;
   logic              done_q;
   logic              aborted_q;
   logic              tmr_load_d;
   logic [TW-1:0]     tmr_val_d;
   logic              tmr_expired;

   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = DEAD_LD;
      case (state_q)
         IDLE: begin
            if (req_valid && (req_code != cur_code_q)) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = DEAD_LD;
            end
         end
         BREAK: begin
            if (!abort && tmr_expired) begin
               tmr_load_d = 1'b1;
               tmr_val_d  = SETTLE_LD;
            end
         end
         default: ;
      endcase
   end

   cyc_timer #(.W(TW)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_load_d),
      .value_i   (tmr_val_d),
      .expired_o (tmr_expired)
   );

   // mid only ever comes from mid_q so the analog array never sees decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mid_q      <= RST_CODE;
         cur_code_q <= RST_CODE;
         nxt_code_q <= RST_CODE;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  nxt_code_q <= req_code;
                  if (req_code == cur_code_q) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= BREAK;
                     mid_q   <= PARK_CODE;
                  end
               end
            end
            BREAK: begin
               if (abort) begin
                  state_q   <= IDLE;
                  mid_q     <= cur_code_q;
                  aborted_q <= 1'b1;
               end else if (tmr_expired) begin
                  state_q <= MAKE;
                  mid_q   <= nxt_code_q;
               end
            end
            MAKE: begin
               if (tmr_expired) begin
                  state_q    <= IDLE;
                  cur_code_q <= nxt_code_q;
                  done_q     <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mid       = mid_q;
   assign done      = done_q;
   assign aborted   = aborted_q;
   assign busy      = (state_q != IDLE);
   assign req_ready = (state_q == IDLE);

endmodule

// File: tb/tb_pmos_bulk_seq.sv
// tb/tb_pmos_bulk_seq.sv - self-checking bench for pmos_bulk_seq
module tb_pmos_bulk_seq;

   localparam int         NBIT   = 2;
   localparam int         DEAD   = 4;
   localparam int         SETTLE = 8;
   localparam logic [1:0] PARK   = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_code = 2'b00;
   logic       abort = 1'b0;
   logic       req_ready;
   logic [1:0] mid;
   logic       busy;
   logic       done;
   logic       aborted;

   int         tests = 0;
   int         fails = 0;
   logic [1:0] model_cur = 2'b00;

   always #5 clk = ~clk;

   pmos_bulk_seq #(
      .NBIT       (NBIT),
      .DEAD_CYC   (DEAD),
      .SETTLE_CYC (SETTLE),
      .PARK_CODE  (2'b11),
      .RST_CODE   (2'b00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_code  (req_code),
      .req_ready (req_ready),
      .abort     (abort),
      .mid       (mid),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted)
   );

   // Issues one request and checks every cycle up to its done/aborted cycle.
   // abort_at: cycle number (1-based after accept) during which abort is held; 0 = none.
   // Returns positioned at the negedge of the final cycle, so a following call is back-to-back.
   task automatic run_req(input logic [1:0] code, input int abort_at, input bit hold_next,
                          input logic [1:0] next_code, input string tag);
      int         n;
      bit         same;
      bit         brk;
      logic [5:0] obs;
      logic [5:0] expv;
      logic [1:0] e_mid;
      logic       e_busy, e_done, e_ab, e_rdy;
      same = (code == model_cur);
      brk  = !same && abort_at >= 1 && abort_at <= DEAD;
      if (same)     n = 1;
      else if (brk) n = abort_at + 1;
      else          n = DEAD + SETTLE + 1;
      req_valid = 1'b1;
      req_code  = code;
      @(posedge clk); #1;
      if (hold_next) req_code = next_code;
      else           req_valid = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         e_done = 1'b0; e_ab = 1'b0;
         if (same) begin
            e_mid = model_cur; e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b1;
         end else if (k == n && brk) begin
            e_mid = model_cur; e_busy = 1'b0; e_rdy = 1'b1; e_ab = 1'b1;
         end else if (k == n) begin
            e_mid = code; e_busy = 1'b0; e_rdy = 1'b1; e_done = 1'b1;
         end else if (k <= DEAD) begin
            e_mid = PARK; e_busy = 1'b1; e_rdy = 1'b0;
         end else begin
            e_mid = code; e_busy = 1'b1; e_rdy = 1'b0;
         end
         obs  = {mid, busy, done, aborted, req_ready};
         expv = {e_mid, e_busy, e_done, e_ab, e_rdy};
         tests++;
         if (obs !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: {mid,busy,done,aborted,ready} got %b expected %b",
                     tag, k, obs, expv);
         end
         if (k == abort_at) abort = 1'b1;
         if (k < n) begin
            @(posedge clk); #1;
            abort = 1'b0;
         end
      end
      if (!same && !brk) model_cur = code;
   endtask

   task automatic test_idle(input int cycles, input string tag);
      logic [5:0] obs;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk);
         @(negedge clk);
         obs = {mid, busy, done, aborted, req_ready};
         tests++;
         if (obs !== {model_cur, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL %s idle %0d: {mid,busy,done,aborted,ready} got %b expected %b",
                     tag, k, obs, {model_cur, 4'b0001});
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req_valid = 1'b0;
      abort = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({mid, busy, done, aborted} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_hold: {mid,busy,done,aborted} got %b expected 00000",
                  {mid, busy, done, aborted});
      end
      rst_n = 1'b1;
      model_cur = 2'b00;
      test_idle(1, "reset_release");
   endtask

   task automatic test_same;
      run_req(model_cur, 0, 1'b0, 2'b00, "same_code");
      test_idle(1, "same_code_after");
   endtask

   task automatic test_change;
      run_req(2'b10, 0, 1'b0, 2'b00, "change_10");
      test_idle(1, "change_after");
   endtask

   task automatic test_abort;
      run_req(2'b01, 2, 1'b0, 2'b00, "abort_c2");
      test_idle(1, "abort_after");
      run_req(2'b01, 1, 1'b0, 2'b00, "abort_c1");
      run_req(2'b01, DEAD, 1'b0, 2'b00, "abort_last_break");
      run_req(2'b01, DEAD + 3, 1'b0, 2'b00, "abort_in_make");
      run_req(2'b11, 0, 1'b0, 2'b00, "repeat_after_abort");
   endtask

   task automatic test_back_to_back;
      run_req(2'b01, 0, 1'b1, 2'b10, "b2b_first");
      run_req(2'b10, 0, 1'b1, 2'b10, "b2b_second");
      run_req(2'b10, 0, 1'b0, 2'b00, "b2b_same");
      test_idle(1, "b2b_after");
   endtask

   task automatic test_random;
      logic [1:0] c;
      int         a;
      for (int t = 0; t < 24; t++) begin
         c = 2'($urandom_range(0, 3));
         a = 0;
         if (c != model_cur && $urandom_range(0, 3) == 0) a = $urandom_range(1, DEAD + SETTLE);
         run_req(c, a, 1'b0, 2'b00, "random");
         if ($urandom_range(0, 1) == 1) test_idle($urandom_range(1, 2), "random_gap");
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] c;
      c = ~model_cur;
      req_valid = 1'b1;
      req_code  = c;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if ({mid, busy} !== {c, 1'b1}) begin
         fails++;
         $display("FAIL reset_mid_pre: {mid,busy} got %b expected %b", {mid, busy}, {c, 1'b1});
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({mid, busy, done, aborted} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_mid_async: {mid,busy,done,aborted} got %b expected 00000",
                  {mid, busy, done, aborted});
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         tests++;
         if ({done, aborted} !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_pulse: {done,aborted} got %b expected 00", {done, aborted});
         end
      end
      rst_n = 1'b1;
      model_cur = 2'b00;
      test_idle(2, "reset_mid_after");
   endtask

   initial begin
      test_reset;
      test_same;
      test_change;
      test_abort;
      test_back_to_back;
      test_random;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
